iiitb_ptvm_multi: RTL and testbench
===================================

Name: iiitb_ptvm_multi

Overview:
Parametrised successor to the single-fare ticket vending FSM. It supports NUM_TICKETS ticket types with a per-type fare table and three coin denominations, and accumulates credit up to the selected fare. It dispenses a ticket over a valid/ready handshake, returns change, and refunds on cancel. It sits between the coin acceptor/keypad front end and the ticket printer and change dispenser.

Parameters:
CREDIT_W, 8, width of credit, fare and change values (unsigned units)
NUM_TICKETS, 4, number of ticket types
TID_W, 2, width of ticket id; must satisfy 2**TID_W >= NUM_TICKETS
FARES, {8'd12,8'd8,8'd5,8'd3}, packed fare table; fare(i) = FARES[i*CREDIT_W +: CREDIT_W]; every fare is nonzero
COIN1_VAL, 1, credit value of coin_code 2'b01
COIN2_VAL, 2, credit value of coin_code 2'b10
COIN3_VAL, 5, credit value of coin_code 2'b11
TIMEOUT_CYC, 1000, inactivity limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
sel_valid  in  1  ticket selection strobe
sel_id  in  TID_W  selected ticket type
coin_valid  in  1  coin inserted strobe, one cycle per coin
coin_code  in  2  denomination code; 2'b00 is invalid
cancel  in  1  refund request
tkt_valid  out  1  ticket dispense request
tkt_id  out  TID_W  ticket type being dispensed
tkt_ready  in  1  printer accepts the ticket
chg_valid  out  1  change/refund request
chg_amt  out  CREDIT_W  change/refund amount
chg_ready  in  1  change dispenser accepts
coin_reject  out  1  one-cycle pulse: coin not credited, physically returned
credit  out  CREDIT_W  current accumulated credit
busy  out  1  high when state is not IDLE
timeout_evt  out  1  one-cycle pulse on inactivity refund

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; credit, fare, tkt_valid, tkt_id, chg_valid, chg_amt, coin_reject, busy and timeout_evt all 0. Reset mid-operation discards credit with no refund.
- All outputs are registered.
- States:
  - IDLE: sel_valid with sel_id < NUM_TICKETS latches fare(sel_id) and sel_id, then goes to COLLECT. Out-of-range sel_id is ignored. A coin in IDLE gives coin_reject.
  - COLLECT: a valid coin adds its value to credit. If new credit >= fare, go to VEND on the next edge. Code 00 gives coin_reject with no credit change. cancel moves to CHANGE with chg_amt=credit and no ticket; cancel with credit=0 returns to IDLE directly. cancel and coin in the same cycle: cancel wins and the coin is rejected. sel_valid is ignored.
  - VEND: tkt_valid=1 and tkt_id are held stable until tkt_ready. On the handshake, change = credit - fare. Change 0 goes to IDLE with credit cleared; otherwise go to CHANGE. Coins are rejected; cancel and sel_valid are ignored.
  - CHANGE: chg_valid=1 and chg_amt are held until chg_ready, then go to IDLE with credit=0. Coins are rejected.
- Latency:
  - coin completing the fare at edge N: tkt_valid high after edge N+1.
  - tkt_ready seen at edge M: tkt_valid low and chg_valid high (if change > 0) after edge M.
- Width: CREDIT_W must hold max(fare)+max(coin)-1. Addition is unsigned and cannot overflow under that rule.

Optional Feature:
Macro IIITB_PTVM_TIMEOUT_EN.
- Defined: a counter clears on entry to COLLECT and on every accepted coin. Reaching TIMEOUT_CYC-1 cycles idle in COLLECT acts as cancel and pulses timeout_evt for one cycle; a timeout with zero credit goes to IDLE.
- Undefined: COLLECT waits indefinitely, no counter is built, and timeout_evt is tied 0.

Decomposition:
- Package iiitb_ptvm_pkg holds:
  - the state encoding constants (IDLE, COLLECT, VEND, CHANGE);
  - the coin code constants (COIN_NONE=2'b00, COIN1, COIN2, COIN3).
- Sub-module iiitb_ptvm_fare_lut is a combinational decode of sel_id into fare and coin_code into value, with a valid flag.
- FSM, credit register and timeout counter live in the top.

Test Plan:
- sel 0 (fare 3), coin 01 then coin 10, tkt_ready=1 -> tkt_valid/tkt_id=0 one cycle after the 2nd coin; no chg_valid; back to IDLE; credit=0.
- sel 1 (fare 5), coins 10, 11 -> credit=7, ticket id 1, then chg_valid with chg_amt=2; IDLE after chg_ready.
- sel 3 (fare 12), coins 11, 11, then cancel in the same cycle as coin 01 -> coin_reject pulse, chg_amt=10, no tkt_valid.
- Fare reached with tkt_ready held low 5 cycles while coins arrive -> tkt_valid/tkt_id stable, each coin gives coin_reject, credit unchanged.
- Coin in IDLE, code 00 in COLLECT, sel_id=3 with NUM_TICKETS=3 -> coin_reject / ignored as specified; credit stays 0. Then rst_n low mid-COLLECT -> all outputs 0 without a clock edge.
- With IIITB_PTVM_TIMEOUT_EN and TIMEOUT_CYC=10: sel 2, coin 11, no activity -> timeout_evt pulse, chg_amt=5.

Source files
------------

// File: rtl/iiitb_ptvm_pkg.sv
// Shared state and coin-code encodings for the multi-fare ticket vending machine.
package iiitb_ptvm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN1     = 2'b01;
    localparam logic [1:0] COIN2     = 2'b10;
    localparam logic [1:0] COIN3     = 2'b11;

endpackage

// File: rtl/iiitb_ptvm_fare_lut.sv
// Combinational decode: ticket id -> fare, coin code -> credit value, each with a valid flag.
module iiitb_ptvm_fare_lut
    import iiitb_ptvm_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int NUM_TICKETS = 4,
    parameter int TID_W       = 2,
    parameter logic [NUM_TICKETS*CREDIT_W-1:0] FARES = {8'd12, 8'd8, 8'd5, 8'd3},
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 2,
    parameter int COIN3_VAL   = 5
) (
    input  logic [TID_W-1:0]    i_sel_id,
    input  logic [1:0]          i_coin_code,
    output logic [CREDIT_W-1:0] o_fare,
    output logic                o_sel_ok,
    output logic [CREDIT_W-1:0] o_coin_val,
    output logic                o_coin_ok
);

    // Ids at or above NUM_TICKETS never match, so they decode as invalid.
    always_comb begin
        o_fare   = '0;
        o_sel_ok = 1'b0;
        for (int i = 0; i < NUM_TICKETS; i++) begin
            if (i_sel_id == TID_W'(i)) begin
                o_fare   = FARES[i*CREDIT_W +: CREDIT_W];
                o_sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        o_coin_val = '0;
        o_coin_ok  = 1'b1;
        case (i_coin_code)
            COIN1:     o_coin_val = CREDIT_W'(COIN1_VAL);
            COIN2:     o_coin_val = CREDIT_W'(COIN2_VAL);
            COIN3:     o_coin_val = CREDIT_W'(COIN3_VAL);
            COIN_NONE: o_coin_ok  = 1'b0;
            default:   o_coin_ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/iiitb_ptvm_multi.sv
// Multi-fare ticket vending FSM: credit accumulation, ticket/change handshakes, cancel refund.
// Optional inactivity refund enabled by defining IIITB_PTVM_TIMEOUT_EN.
module iiitb_ptvm_multi
    import iiitb_ptvm_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int NUM_TICKETS = 4,
    parameter int TID_W       = 2,
    parameter logic [NUM_TICKETS*CREDIT_W-1:0] FARES = {8'd12, 8'd8, 8'd5, 8'd3},
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 2,
    parameter int COIN3_VAL   = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_valid,
    input  logic [TID_W-1:0]    sel_id,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    output logic                tkt_valid,
    output logic [TID_W-1:0]    tkt_id,
    input  logic                tkt_ready,
    output logic                chg_valid,
    output logic [CREDIT_W-1:0] chg_amt,
    input  logic                chg_ready,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                timeout_evt
);

    if ((2**TID_W) < NUM_TICKETS || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("iiitb_ptvm_multi: TID_W too narrow or TIMEOUT_CYC < 2");
    end

    state_t              r_state, w_nstate;
    logic [CREDIT_W-1:0] r_credit, w_credit_n;
    logic [CREDIT_W-1:0] r_fare, w_fare_n;
    logic [TID_W-1:0]    r_tid, w_tid_n;
    logic [CREDIT_W-1:0] r_chg_amt, w_chg_amt_n;
    logic                r_tkt_valid, r_chg_valid, r_coin_rej, r_busy;
    logic                w_coin_rej, w_coin_acc, w_tmo_hit;
    logic [CREDIT_W-1:0] w_lut_fare, w_coin_val;
    logic                w_sel_ok, w_coin_ok;

    iiitb_ptvm_fare_lut #(
        .CREDIT_W(CREDIT_W), .NUM_TICKETS(NUM_TICKETS), .TID_W(TID_W), .FARES(FARES),
        .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL), .COIN3_VAL(COIN3_VAL)
    ) u_lut (
        .i_sel_id(sel_id), .i_coin_code(coin_code),
        .o_fare(w_lut_fare), .o_sel_ok(w_sel_ok),
        .o_coin_val(w_coin_val), .o_coin_ok(w_coin_ok)
    );

`ifdef IIITB_PTVM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_evt, w_tmo_evt;

    assign w_tmo_hit = (r_state == COLLECT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_tmo_evt <= 1'b0;
        end else begin
            r_tmo_evt <= w_tmo_evt;
            if (r_state != COLLECT || w_coin_acc) r_tmo_cnt <= '0;
            else if (!w_tmo_hit)                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
    assign timeout_evt = r_tmo_evt;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        w_nstate    = r_state;
        w_credit_n  = r_credit;
        w_fare_n    = r_fare;
        w_tid_n     = r_tid;
        w_chg_amt_n = r_chg_amt;
        w_coin_rej  = 1'b0;
        w_coin_acc  = 1'b0;
`ifdef IIITB_PTVM_TIMEOUT_EN
        w_tmo_evt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_coin_rej = coin_valid;
                if (sel_valid && w_sel_ok) begin
                    w_fare_n = w_lut_fare;
                    w_tid_n  = sel_id;
                    w_nstate = COLLECT;
                end
            end
            COLLECT: begin
                // Fare is checked on registered credit, giving one settle cycle before VEND.
                if (r_credit >= r_fare) begin
                    w_coin_rej = coin_valid;
                    w_nstate   = VEND;
                end else if (cancel || w_tmo_hit) begin
                    w_coin_rej = coin_valid;
`ifdef IIITB_PTVM_TIMEOUT_EN
                    w_tmo_evt  = !cancel;
`endif
                    if (r_credit == '0) begin
                        w_nstate = IDLE;
                    end else begin
                        w_chg_amt_n = r_credit;
                        w_nstate    = CHANGE;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit_n = r_credit + w_coin_val;
                        w_coin_acc = 1'b1;
                    end else begin
                        w_coin_rej = 1'b1;
                    end
                end
            end
            VEND: begin
                w_coin_rej = coin_valid;
                if (tkt_ready) begin
                    if (r_credit == r_fare) begin
                        w_credit_n = '0;
                        w_nstate   = IDLE;
                    end else begin
                        w_chg_amt_n = r_credit - r_fare;
                        w_nstate    = CHANGE;
                    end
                end
            end
            CHANGE: begin
                w_coin_rej = coin_valid;
                if (chg_ready) begin
                    w_credit_n  = '0;
                    w_chg_amt_n = '0;
                    w_nstate    = IDLE;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_fare      <= '0;
            r_tid       <= '0;
            r_chg_amt   <= '0;
            r_tkt_valid <= 1'b0;
            r_chg_valid <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_credit    <= w_credit_n;
            r_fare      <= w_fare_n;
            r_tid       <= w_tid_n;
            r_chg_amt   <= w_chg_amt_n;
            r_tkt_valid <= (w_nstate == VEND);
            r_chg_valid <= (w_nstate == CHANGE);
            r_coin_rej  <= w_coin_rej;
            r_busy      <= (w_nstate != IDLE);
        end
    end

    assign tkt_valid   = r_tkt_valid;
    assign tkt_id      = r_tid;
    assign chg_valid   = r_chg_valid;
    assign chg_amt     = r_chg_amt;
    assign coin_reject = r_coin_rej;
    assign credit      = r_credit;
    assign busy        = r_busy;

endmodule

// File: tb/tb_iiitb_ptvm_multi.sv
// Bench for iiitb_ptvm_multi: per-cycle reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_iiitb_ptvm_multi;

    localparam int TO_CYC = 10;
    localparam int NT     = 4;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       sel_valid = 1'b0, coin_valid = 1'b0, cancel = 1'b0;
    logic [1:0] sel_id = '0, coin_code = '0;
    logic       tkt_ready = 1'b0, chg_ready = 1'b0;

    logic       tkt_valid, chg_valid, coin_reject, busy, timeout_evt;
    logic [1:0] tkt_id;
    logic [7:0] chg_amt, credit;

    logic       tkt_valid3, chg_valid3, coin_reject3, busy3, timeout_evt3;
    logic [1:0] tkt_id3;
    logic [7:0] chg_amt3, credit3;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    iiitb_ptvm_multi #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_id(sel_id),
        .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
        .tkt_valid(tkt_valid), .tkt_id(tkt_id), .tkt_ready(tkt_ready),
        .chg_valid(chg_valid), .chg_amt(chg_amt), .chg_ready(chg_ready),
        .coin_reject(coin_reject), .credit(credit), .busy(busy), .timeout_evt(timeout_evt)
    );

    // Three-ticket variant: id 3 must be ignored.
    iiitb_ptvm_multi #(.NUM_TICKETS(3), .FARES(24'h080503), .TIMEOUT_CYC(TO_CYC)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_id(sel_id),
        .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
        .tkt_valid(tkt_valid3), .tkt_id(tkt_id3), .tkt_ready(tkt_ready),
        .chg_valid(chg_valid3), .chg_amt(chg_amt3), .chg_ready(chg_ready),
        .coin_reject(coin_reject3), .credit(credit3), .busy(busy3), .timeout_evt(timeout_evt3)
    );

    function automatic logic [7:0] fare_of(input logic [1:0] id);
        case (id)
            2'd0: return 8'd3;
            2'd1: return 8'd5;
            2'd2: return 8'd8;
            default: return 8'd12;
        endcase
    endfunction

    function automatic logic [7:0] coin_of(input logic [1:0] c);
        case (c)
            2'b01: return 8'd1;
            2'b10: return 8'd2;
            2'b11: return 8'd5;
            default: return 8'd0;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 collecting, 2 ticket offered, 3 change offered.
    int         m_ph, m_idle;
    logic [7:0] m_credit, m_fare, m_chg;
    logic [1:0] m_tid;
    logic       m_rej, m_tmo, tmo_now;

`ifdef IIITB_PTVM_TIMEOUT_EN
    assign tmo_now = (m_ph == 1) && (m_idle == TO_CYC - 1);
`else
    assign tmo_now = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_idle <= 0; m_credit <= '0; m_fare <= '0; m_chg <= '0;
            m_tid <= '0; m_rej <= 1'b0; m_tmo <= 1'b0;
        end else begin
            m_rej <= coin_valid && !(m_ph == 1 && m_credit < m_fare && !cancel && !tmo_now
                                     && coin_code != 2'b00);
            m_tmo <= 1'b0;
            case (m_ph)
                0: if (sel_valid && int'(sel_id) < NT) begin
                       m_ph <= 1; m_fare <= fare_of(sel_id); m_tid <= sel_id; m_idle <= 0;
                   end
                1: if (m_credit >= m_fare) m_ph <= 2;
                   else if (cancel || tmo_now) begin
                       m_tmo <= !cancel;
                       if (m_credit == 0) m_ph <= 0;
                       else begin m_ph <= 3; m_chg <= m_credit; end
                   end else if (coin_valid && coin_code != 2'b00) begin
                       m_credit <= m_credit + coin_of(coin_code); m_idle <= 0;
                   end else m_idle <= m_idle + 1;
                2: if (tkt_ready) begin
                       if (m_credit == m_fare) begin m_ph <= 0; m_credit <= '0; end
                       else begin m_ph <= 3; m_chg <= m_credit - m_fare; end
                   end
                default: if (chg_ready) begin m_ph <= 0; m_credit <= '0; m_chg <= '0; end
            endcase
        end
    end

    logic [22:0] got, expv;
    assign got  = {tkt_valid, tkt_id, chg_valid, chg_amt, coin_reject, credit, busy, timeout_evt};
    assign expv = {m_ph == 2, m_tid, m_ph == 3, m_chg, m_rej, m_credit, m_ph != 0, m_tmo};

    always @(negedge clk) begin
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL model t=%0t got %h want %h", $time, got, expv);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        sel_valid = 0; coin_valid = 0; cancel = 0; sel_id = 0; coin_code = 0;
        tkt_ready = 0; chg_ready = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic sel(input logic [1:0] id);
        sel_valid = 1; sel_id = id; tick(); sel_valid = 0; sel_id = 0;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1; coin_code = c; tick(); coin_valid = 0; coin_code = 0;
    endtask

    initial begin
        int cyc;
        #1 rst_n = 0;
        #1 chk("reset_outputs", 32'(got), 0);
        tick();
        rst_n = 1;

        // Exact fare 3 with coins 1+2: ticket one cycle after the second coin, no change.
        do_reset();
        tkt_ready = 1;
        sel(2'd0);          chk("s1_busy", 32'(busy), 1);
        coin(2'b01);        chk("s1_credit1", 32'(credit), 1);
        coin(2'b10);        chk("s1_credit3", 32'(credit), 3);
                            chk("s1_tkt_early", 32'(tkt_valid), 0);
        tick();             chk("s1_tkt_valid", 32'(tkt_valid), 1);
                            chk("s1_tkt_id", 32'(tkt_id), 0);
        tick();             chk("s1_tkt_done", 32'(tkt_valid), 0);
                            chk("s1_no_chg", 32'(chg_valid), 0);
                            chk("s1_idle", 32'(busy), 0);
                            chk("s1_credit0", 32'(credit), 0);

        // Fare 5 paid with 2+5: change 2.
        do_reset();
        sel(2'd1); coin(2'b10); coin(2'b11);
        chk("s2_credit7", 32'(credit), 7);
        tick();             chk("s2_tkt_id", 32'(tkt_id), 1);
        tkt_ready = 1; tick(); tkt_ready = 0;
        chk("s2_tkt_low", 32'(tkt_valid), 0);
        chk("s2_chg_valid", 32'(chg_valid), 1);
        chk("s2_chg_amt", 32'(chg_amt), 2);
        tick();             chk("s2_chg_hold", 32'(chg_valid), 1);
        chg_ready = 1; tick(); chg_ready = 0;
        chk("s2_idle", 32'(busy), 0);
        chk("s2_credit0", 32'(credit), 0);

        // Fare 12, credit 10, cancel together with a coin: refund 10, coin rejected.
        do_reset();
        sel(2'd3); coin(2'b11); coin(2'b11);
        chk("s3_credit10", 32'(credit), 10);
        cancel = 1; coin_valid = 1; coin_code = 2'b01; tick();
        cancel = 0; coin_valid = 0; coin_code = 0;
        chk("s3_reject", 32'(coin_reject), 1);
        chk("s3_chg_amt", 32'(chg_amt), 10);
        chk("s3_chg_valid", 32'(chg_valid), 1);
        chk("s3_no_tkt", 32'(tkt_valid), 0);
        tick();             chk("s3_reject_pulse", 32'(coin_reject), 0);
        chg_ready = 1; tick(); chg_ready = 0;
        chk("s3_idle", 32'(busy), 0);

        // Fare 8 reached, printer stalled while coins keep arriving.
        do_reset();
        sel(2'd2); coin(2'b11); coin(2'b11);
        coin(2'b01);
        chk("s4_pend_reject", 32'(coin_reject), 1);
        chk("s4_pend_credit", 32'(credit), 10);
        for (int i = 0; i < 5; i++) begin
            coin(2'(i % 3 + 1));
            chk("s4_tkt_valid", 32'(tkt_valid), 1);
            chk("s4_tkt_id", 32'(tkt_id), 2);
            chk("s4_reject", 32'(coin_reject), 1);
            chk("s4_credit", 32'(credit), 10);
        end
        tkt_ready = 1; tick(); tkt_ready = 0;
        chk("s4_chg_amt", 32'(chg_amt), 2);
        chg_ready = 1; tick(); chg_ready = 0;

        // Rejects, out-of-range selection, zero-credit cancel, async reset mid-collect.
        do_reset();
        coin(2'b01);
        chk("s5_idle_reject", 32'(coin_reject), 1);
        chk("s5_idle_busy", 32'(busy), 0);
        sel(2'd3);
        chk("s5_dut3_ignored", 32'({tkt_valid3, tkt_id3, chg_valid3, chg_amt3, coin_reject3,
                                     credit3, busy3, timeout_evt3}), 0);
        chk("s5_sel3_busy", 32'(busy), 1);
        coin(2'b00);
        chk("s5_code00_reject", 32'(coin_reject), 1);
        chk("s5_code00_credit", 32'(credit), 0);
        cancel = 1; tick(); cancel = 0;
        chk("s5_cancel0_idle", 32'(busy), 0);
        chk("s5_cancel0_nochg", 32'(chg_valid), 0);
        sel(2'd0); coin(2'b01);
        chk("s5_credit1", 32'(credit), 1);
        rst_n = 0;
        #1 chk("s5_async_reset", 32'(got), 0);
        tick();
        rst_n = 1;

`ifdef IIITB_PTVM_TIMEOUT_EN
        do_reset();
        sel(2'd2); coin(2'b11);
        cyc = 0;
        while (!timeout_evt && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("s6_timeout_cycles", 32'(cyc), 10);
        chk("s6_timeout_chg", 32'(chg_amt), 5);
        chk("s6_timeout_chg_valid", 32'(chg_valid), 1);
        tick();             chk("s6_timeout_pulse", 32'(timeout_evt), 0);
        chg_ready = 1; tick(); chg_ready = 0;
`else
        do_reset();
        sel(2'd2); coin(2'b11);
        cyc = 0;
        repeat (15) begin tick(); cyc++; end
        chk("s6_wait_cycles", 32'(cyc), 15);
        chk("s6_still_busy", 32'(busy), 1);
        chk("s6_credit_kept", 32'(credit), 5);
        chk("s6_no_timeout", 32'(timeout_evt), 0);
        cancel = 1; tick(); cancel = 0;
        chg_ready = 1; tick(); chg_ready = 0;
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
